wb_stage_pipe: RTL and testbench

Registered, parametrised write-back stage for the pipelined core. It accepts one retiring instruction per handshake from the MEM stage and selects the result source (ALU, load data or U/J-type value). For loads it waits for a variable-latency memory response, then aligns and sign-extends the load data. It issues a one-cycle register-file write and keeps a retire counter.

---
 rtl/wb_pkg.sv | 37 +++
 rtl/wb_stage_pipe_if.sv | 42 ++++
 rtl/wb_load_align.sv | 65 ++++++
 rtl/wb_stage_pipe.sv | 136 +++++++++++++
 tb/tb_wb_stage_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back stage: opcodes, result-source
// encodings, load size codes and the FSM state type.
package wb_pkg;

   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_U   = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} wb_state_e;

   typedef enum logic [1:0] {U_RET, U_IMM, U_PCOFF} u_sel_e;

   // JAL/JALR and any unrecognised opcode fall back to the return address.
   function automatic u_sel_e u_select(input logic [6:0] opcode);
      u_sel_e sel;
      case (opcode)
         OP_LUI:   sel = U_IMM;
         OP_AUIPC: sel = U_PCOFF;
         default:  sel = U_RET;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-to-WB handshake, memory response and register-file write bundle.
// The master modport drives the stage; the slave modport is the stage itself.
interface wb_stage_pipe_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [6:0]         in_opcode;
   logic [2:0]         in_funct3;
   logic [RADDR_W-1:0] in_rd;
   logic               in_reg_write;
   logic [1:0]         in_memtoreg;
   logic [XLEN-1:0]    in_alu_out;
   logic [XLEN-1:0]    in_return_addr;
   logic [XLEN-1:0]    in_imm_out;
   logic [XLEN-1:0]    in_pc_signed_offset;
   logic               mem_rsp_valid;
   logic [XLEN-1:0]    mem_rsp_data;
   logic               rf_we;
   logic [RADDR_W-1:0] rf_waddr;
   logic [XLEN-1:0]    rf_wdata;
   logic               err_misalign;
   logic               err_stray_rsp;
   logic [CNT_W-1:0]   retire_cnt;

   modport master (
      output in_valid, in_opcode, in_funct3, in_rd, in_reg_write, in_memtoreg,
             in_alu_out, in_return_addr, in_imm_out, in_pc_signed_offset,
             mem_rsp_valid, mem_rsp_data,
      input  in_ready, rf_we, rf_waddr, rf_wdata, err_misalign, err_stray_rsp, retire_cnt
   );

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_rd, in_reg_write, in_memtoreg,
             in_alu_out, in_return_addr, in_imm_out, in_pc_signed_offset,
             mem_rsp_valid, mem_rsp_data,
      output in_ready, rf_we, rf_waddr, rf_wdata, err_misalign, err_stray_rsp, retire_cnt
   );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word/dword out of
// the memory word, extends it, and flags misaligned or unsupported accesses.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]                    i_funct3,
   input  logic [$clog2(XLEN/8)-1:0]     i_ofs,
   input  logic [XLEN-1:0]               i_data,
   output logic [XLEN-1:0]               o_data,
   output logic                          o_misalign
);
   localparam int unsigned OFS_W = $clog2(XLEN/8);

   logic [OFS_W+2:0] w_bit_ofs;
   logic [XLEN-1:0]  w_shift;
   logic [63:0]      w_ext;

   assign w_bit_ofs = {i_ofs, 3'b000};
   assign w_shift   = i_data >> w_bit_ofs;

   // Extension is done at 64 bits and then cut to XLEN, so one code path
   // serves both datapath widths.
   always_comb begin
      w_ext      = 64'(i_data);
      o_misalign = 1'b0;
      case (i_funct3)
         F3_LB:  w_ext = {{56{w_shift[7]}}, w_shift[7:0]};
         F3_LBU: w_ext = {56'd0, w_shift[7:0]};
         F3_LH: begin
            w_ext      = {{48{w_shift[15]}}, w_shift[15:0]};
            o_misalign = i_ofs[0];
         end
         F3_LHU: begin
            w_ext      = {48'd0, w_shift[15:0]};
            o_misalign = i_ofs[0];
         end
         F3_LW: begin
            w_ext      = {{32{w_shift[31]}}, w_shift[31:0]};
            o_misalign = |i_ofs[1:0];
         end
         F3_LWU: begin
            if (XLEN == 64) begin
               w_ext      = {32'd0, w_shift[31:0]};
               o_misalign = |i_ofs[1:0];
            end else begin
               o_misalign = 1'b1;
            end
         end
         F3_LD: begin
            if (XLEN == 64) begin
               w_ext      = 64'(w_shift);
               o_misalign = |i_ofs;
            end else begin
               o_misalign = 1'b1;
            end
         end
         default: o_misalign = 1'b1;
      endcase
   end

   assign o_data = w_ext[XLEN-1:0];

endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage: accepts one retiring instruction per handshake, waits for
// load data when needed, and issues a registered one-cycle register-file write.
module wb_stage_pipe
   import wb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_stage_pipe_if.slave  bus
);
   localparam int unsigned OFS_W = $clog2(XLEN/8);

   wb_state_e          r_state;
   wb_state_e          w_state_next;
   logic               w_in_ready;
   logic               w_hs;
   logic               w_rsp_in_wait;
   logic [XLEN-1:0]    w_u_data;
   logic [XLEN-1:0]    w_nl_data;
   logic [XLEN-1:0]    w_ld_data;
   logic               w_ld_misalign;

   logic [2:0]         r_funct3;
   logic [RADDR_W-1:0] r_rd;
   logic               r_reg_write;
   logic [OFS_W-1:0]   r_ofs;

   logic               r_rf_we;
   logic [RADDR_W-1:0] r_rf_waddr;
   logic [XLEN-1:0]    r_rf_wdata;
   logic               r_err_misalign;
   logic               r_err_stray;
   logic [CNT_W-1:0]   r_retire_cnt;

   assign w_in_ready    = (r_state != WAIT_MEM);
   assign w_hs          = bus.in_valid && w_in_ready;
   assign w_rsp_in_wait = bus.mem_rsp_valid && (r_state == WAIT_MEM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE, COMMIT: begin
            if (w_hs) begin
               w_state_next = (bus.in_memtoreg == WB_MEM) ? WAIT_MEM : COMMIT;
            end else begin
               w_state_next = IDLE;
            end
         end
         WAIT_MEM: begin
            if (bus.mem_rsp_valid) begin
               w_state_next = COMMIT;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_u_data = bus.in_return_addr;
      case (u_select(bus.in_opcode))
         U_IMM:   w_u_data = bus.in_imm_out;
         U_PCOFF: w_u_data = bus.in_pc_signed_offset;
         default: w_u_data = bus.in_return_addr;
      endcase
      w_nl_data = (bus.in_memtoreg == WB_U) ? w_u_data : bus.in_alu_out;
   end

   wb_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .i_funct3   (r_funct3),
      .i_ofs      (r_ofs),
      .i_data     (bus.mem_rsp_data),
      .o_data     (w_ld_data),
      .o_misalign (w_ld_misalign)
   );

   // Non-loads commit straight from the handshake; loads commit from the
   // fields captured at acceptance once the response arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_funct3       <= '0;
         r_rd           <= '0;
         r_reg_write    <= 1'b0;
         r_ofs          <= '0;
         r_rf_we        <= 1'b0;
         r_rf_waddr     <= '0;
         r_rf_wdata     <= '0;
         r_err_misalign <= 1'b0;
         r_err_stray    <= 1'b0;
         r_retire_cnt   <= '0;
      end else begin
         r_rf_we        <= 1'b0;
         r_err_misalign <= 1'b0;
         r_err_stray    <= bus.mem_rsp_valid && (r_state != WAIT_MEM);
         if (w_hs) begin
            r_funct3    <= bus.in_funct3;
            r_rd        <= bus.in_rd;
            r_reg_write <= bus.in_reg_write;
            r_ofs       <= bus.in_alu_out[OFS_W-1:0];
         end
         if (w_hs && (bus.in_memtoreg != WB_MEM)) begin
            r_rf_we      <= bus.in_reg_write && (bus.in_rd != '0);
            r_rf_waddr   <= bus.in_rd;
            r_rf_wdata   <= w_nl_data;
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
         end else if (w_rsp_in_wait) begin
            r_rf_we        <= r_reg_write && (r_rd != '0) && !w_ld_misalign;
            r_rf_waddr     <= r_rd;
            r_rf_wdata     <= w_ld_data;
            r_err_misalign <= w_ld_misalign;
            r_retire_cnt   <= r_retire_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.rf_we         = r_rf_we;
   assign bus.rf_waddr      = r_rf_waddr;
   assign bus.rf_wdata      = r_rf_wdata;
   assign bus.err_misalign  = r_err_misalign;
   assign bus.err_stray_rsp = r_err_stray;
   assign bus.retire_cnt    = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Drives one stimulus stream into an XLEN=32 and an XLEN=64 write-back stage and
// scores both against a width-aware reference model through per-cycle queues.
module tb_wb_stage_pipe;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  m2r;
      logic [63:0] alu;
      logic [63:0] ret;
      logic [63:0] imm;
      logic [63:0] pco;
   } ins_t;

   typedef struct packed {
      int          cyc;
      logic        we;
      logic [4:0]  waddr;
      logic [63:0] wdata;
      logic        chk;
      logic        mis;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        d_valid, d_rw, d_rsp_valid;
   logic [6:0]  d_op;
   logic [2:0]  d_f3;
   logic [4:0]  d_rd;
   logic [1:0]  d_m2r;
   logic [63:0] d_alu, d_ret, d_imm, d_pco, d_rsp_data;

   wb_stage_pipe_if #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) bus32 ();
   wb_stage_pipe_if #(.XLEN(64), .RADDR_W(5), .CNT_W(32)) bus64 ();

   assign bus32.in_valid            = d_valid;
   assign bus32.in_opcode           = d_op;
   assign bus32.in_funct3           = d_f3;
   assign bus32.in_rd               = d_rd;
   assign bus32.in_reg_write        = d_rw;
   assign bus32.in_memtoreg         = d_m2r;
   assign bus32.in_alu_out          = d_alu[31:0];
   assign bus32.in_return_addr      = d_ret[31:0];
   assign bus32.in_imm_out          = d_imm[31:0];
   assign bus32.in_pc_signed_offset = d_pco[31:0];
   assign bus32.mem_rsp_valid       = d_rsp_valid;
   assign bus32.mem_rsp_data        = d_rsp_data[31:0];

   assign bus64.in_valid            = d_valid;
   assign bus64.in_opcode           = d_op;
   assign bus64.in_funct3           = d_f3;
   assign bus64.in_rd               = d_rd;
   assign bus64.in_reg_write        = d_rw;
   assign bus64.in_memtoreg         = d_m2r;
   assign bus64.in_alu_out          = d_alu;
   assign bus64.in_return_addr      = d_ret;
   assign bus64.in_imm_out          = d_imm;
   assign bus64.in_pc_signed_offset = d_pco;
   assign bus64.mem_rsp_valid       = d_rsp_valid;
   assign bus64.mem_rsp_data        = d_rsp_data;

   wb_stage_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   wb_stage_pipe #(.XLEN(64), .RADDR_W(5), .CNT_W(32)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus64)
   );

   exp_t q[2][$];
   int   stray_q[$];
   int   n_commit[2];
   bit   busy = 1'b0;
   ins_t pend;

   task automatic check(input string name, input int idx, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s x%0d cyc %0d: got %h want %h", name, (idx == 0) ? 32 : 64,
                  cyc, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] trunc(input int xlen, input logic [63:0] v);
      return (xlen == 32) ? {32'd0, v[31:0]} : v;
   endfunction

   function automatic logic [63:0] u_val(input ins_t i);
      case (i.op)
         7'b0110111: return i.imm;
         7'b0010111: return i.pco;
         default:    return i.ret;
      endcase
   endfunction

   function automatic exp_t model_nonload(input int xlen, input ins_t i, input int c);
      exp_t e;
      e.cyc   = c;
      e.we    = i.rw && (i.rd != 0);
      e.waddr = i.rd;
      e.wdata = trunc(xlen, (i.m2r == 2'd2) ? u_val(i) : i.alu);
      e.chk   = 1'b1;
      e.mis   = 1'b0;
      return e;
   endfunction

   function automatic exp_t model_load(input int xlen, input ins_t i, input logic [63:0] data,
                                       input int c);
      exp_t        e;
      int          nb, ofs, sz;
      bit          legal, sgn;
      logic [63:0] d, m, v;
      nb    = xlen / 8;
      ofs   = int'(i.alu[2:0]) % nb;
      d     = trunc(xlen, data);
      sz    = 1 << i.f3[1:0];
      sgn   = !i.f3[2];
      legal = (i.f3 != 3'd7) && (xlen == 64 || (i.f3 != 3'd3 && i.f3 != 3'd6));
      if (!legal) begin
         e.wdata = d;
         e.mis   = 1'b1;
         e.chk   = 1'b1;
      end else begin
         e.mis = (ofs % sz) != 0;
         m     = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
         v     = (d >> (8 * ofs)) & m;
         if (sgn && v[8*sz-1]) v = v | ~m;
         e.wdata = trunc(xlen, v);
         e.chk   = !e.mis;
      end
      e.cyc   = c;
      e.waddr = i.rd;
      e.we    = i.rw && (i.rd != 0) && !e.mis;
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic do_cycle(input bit v, input ins_t i, input bit rsp, input logic [63:0] rdata);
      bit was_busy;
      @(posedge clk);
      #1;
      was_busy = busy;
      check("in_ready", 0, 64'(bus32.in_ready), 64'(!was_busy));
      check("in_ready", 1, 64'(bus64.in_ready), 64'(!was_busy));
      d_valid     = v;
      d_op        = i.op;
      d_f3        = i.f3;
      d_rd        = i.rd;
      d_rw        = i.rw;
      d_m2r       = i.m2r;
      d_alu       = i.alu;
      d_ret       = i.ret;
      d_imm       = i.imm;
      d_pco       = i.pco;
      d_rsp_valid = rsp;
      d_rsp_data  = rdata;
      if (rsp) begin
         if (was_busy) begin
            q[0].push_back(model_load(32, pend, rdata, cyc + 1));
            q[1].push_back(model_load(64, pend, rdata, cyc + 1));
            busy = 1'b0;
         end else begin
            stray_q.push_back(cyc + 1);
         end
      end
      if (v && !was_busy) begin
         if (i.m2r == 2'd1) begin
            busy = 1'b1;
            pend = i;
         end else begin
            q[0].push_back(model_nonload(32, i, cyc + 1));
            q[1].push_back(model_nonload(64, i, cyc + 1));
         end
      end
   endtask

   task automatic idle();
      do_cycle(1'b0, '0, 1'b0, '0);
   endtask

   task automatic run_load(input ins_t i, input int lat, input logic [63:0] data);
      do_cycle(1'b1, i, 1'b0, '0);
      repeat (lat - 1) do_cycle(1'b0, i, 1'b0, '0);
      do_cycle(1'b0, i, 1'b1, data);
   endtask

   function automatic ins_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                               input logic rw, input logic [1:0] m2r, input logic [63:0] alu,
                               input logic [63:0] ret, input logic [63:0] imm,
                               input logic [63:0] pco);
      ins_t i;
      i.op = op; i.f3 = f3; i.rd = rd; i.rw = rw; i.m2r = m2r;
      i.alu = alu; i.ret = ret; i.imm = imm; i.pco = pco;
      return i;
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      case ($urandom_range(0, 5))
         0:       i.op = 7'b1101111;
         1:       i.op = 7'b1100111;
         2:       i.op = 7'b0110111;
         3:       i.op = 7'b0010111;
         4:       i.op = 7'b0110011;
         default: i.op = 7'($urandom);
      endcase
      i.f3  = 3'($urandom);
      i.rd  = 5'($urandom);
      i.rw  = ($urandom_range(0, 3) != 0);
      i.m2r = 2'($urandom);
      i.alu = r64();
      i.ret = r64();
      i.imm = r64();
      i.pco = r64();
      return i;
   endfunction

   // ---------------- monitor ----------------
   task automatic check_inst(input int idx, input logic we, input logic [4:0] waddr,
                             input logic [63:0] wdata, input logic mis, input logic [31:0] cnt);
      exp_t e;
      while (q[idx].size() > 0 && q[idx][0].cyc < cyc) begin
         e = q[idx].pop_front();
         check("missed_commit", idx, 64'(e.cyc), 64'(cyc));
      end
      if (q[idx].size() > 0 && q[idx][0].cyc == cyc) begin
         e = q[idx].pop_front();
         n_commit[idx]++;
         check("rf_we", idx, 64'(we), 64'(e.we));
         check("rf_waddr", idx, 64'(waddr), 64'(e.waddr));
         if (e.chk) check("rf_wdata", idx, wdata, e.wdata);
         check("err_misalign", idx, 64'(mis), 64'(e.mis));
         check("retire_cnt", idx, 64'(cnt), 64'(n_commit[idx]));
      end else begin
         check("idle_pulses", idx, {62'd0, we, mis}, 64'd0);
         check("retire_hold", idx, 64'(cnt), 64'(n_commit[idx]));
      end
   endtask

   always @(negedge clk) begin
      logic exp_stray;
      if (!rst_n) begin
         n_commit[0] = 0;
         n_commit[1] = 0;
         check("rst_we", 0, 64'(bus32.rf_we), 64'd0);
         check("rst_we", 1, 64'(bus64.rf_we), 64'd0);
         check("rst_waddr", 1, 64'(bus64.rf_waddr), 64'd0);
         check("rst_wdata", 0, 64'(bus32.rf_wdata), 64'd0);
         check("rst_wdata", 1, bus64.rf_wdata, 64'd0);
         check("rst_err", 0, {62'd0, bus32.err_misalign, bus32.err_stray_rsp}, 64'd0);
         check("rst_err", 1, {62'd0, bus64.err_misalign, bus64.err_stray_rsp}, 64'd0);
         check("rst_cnt", 0, 64'(bus32.retire_cnt), 64'd0);
         check("rst_cnt", 1, 64'(bus64.retire_cnt), 64'd0);
         check("rst_ready", 0, 64'(bus32.in_ready), 64'd1);
         check("rst_ready", 1, 64'(bus64.in_ready), 64'd1);
      end else begin
         check_inst(0, bus32.rf_we, bus32.rf_waddr, 64'(bus32.rf_wdata), bus32.err_misalign,
                    bus32.retire_cnt);
         check_inst(1, bus64.rf_we, bus64.rf_waddr, bus64.rf_wdata, bus64.err_misalign,
                    bus64.retire_cnt);
         exp_stray = 1'b0;
         if (stray_q.size() > 0 && stray_q[0] == cyc) begin
            exp_stray = 1'b1;
            void'(stray_q.pop_front());
         end
         check("err_stray_rsp", 0, 64'(bus32.err_stray_rsp), 64'(exp_stray));
         check("err_stray_rsp", 1, 64'(bus64.err_stray_rsp), 64'(exp_stray));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      ins_t ins;
      bit   v, rsp, was_busy;
      int   wait_left;
      d_valid = 1'b0; d_rw = 1'b0; d_rsp_valid = 1'b0;
      d_op = '0; d_f3 = '0; d_rd = '0; d_m2r = '0;
      d_alu = '0; d_ret = '0; d_imm = '0; d_pco = '0; d_rsp_data = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // back-to-back ALU ops
      do_cycle(1'b1, mk(7'h33, 3'd0, 5'd1, 1'b1, 2'd0, 64'h11, 0, 0, 0), 1'b0, '0);
      do_cycle(1'b1, mk(7'h33, 3'd0, 5'd2, 1'b1, 2'd0, 64'h22, 0, 0, 0), 1'b0, '0);
      do_cycle(1'b1, mk(7'h33, 3'd0, 5'd3, 1'b1, 2'd0, 64'h33, 0, 0, 0), 1'b0, '0);
      idle();
      // LB / LBU at offset 2 with 4-cycle response
      run_load(mk(7'h03, 3'b000, 5'd6, 1'b1, 2'd1, 64'd2, 0, 0, 0), 4, 64'h12F45678);
      run_load(mk(7'h03, 3'b100, 5'd7, 1'b1, 2'd1, 64'd2, 0, 0, 0), 4, 64'h12F45678);
      // misaligned LH
      run_load(mk(7'h03, 3'b001, 5'd5, 1'b1, 2'd1, 64'd1, 0, 0, 0), 2, 64'hCAFEBABE);
      idle();
      // U-group sources
      do_cycle(1'b1, mk(7'b0110111, 3'd0, 5'd8, 1'b1, 2'd2, 0, 0, 64'hABCDE000, 0), 1'b0, '0);
      do_cycle(1'b1, mk(7'b0010111, 3'd0, 5'd9, 1'b1, 2'd2, 0, 0, 0, 64'h1004), 1'b0, '0);
      do_cycle(1'b1, mk(7'b1101111, 3'd0, 5'd10, 1'b1, 2'd2, 0, 64'h208, 0, 0), 1'b0, '0);
      do_cycle(1'b1, mk(7'b0110111, 3'd0, 5'd0, 1'b1, 2'd2, 0, 0, 64'hABCDE000, 0), 1'b0, '0);
      idle();
      // stray response while idle, then LWU at offset 4
      do_cycle(1'b0, '0, 1'b1, 64'h5A5A5A5A);
      idle();
      run_load(mk(7'h03, 3'b110, 5'd11, 1'b1, 2'd1, 64'd4, 0, 0, 0), 3,
               64'h80000000_00000000);
      idle();

      wait_left = 0;
      for (int n = 0; n < 3000; n++) begin
         ins      = rand_ins();
         v        = ($urandom_range(0, 3) != 0);
         was_busy = busy;
         if (busy) begin
            wait_left--;
            rsp = (wait_left == 0);
         end else begin
            rsp = ($urandom_range(0, 9) == 0);
         end
         do_cycle(v, ins, rsp, r64());
         if (busy && !was_busy) wait_left = $urandom_range(1, 5);
      end
      while (busy) do_cycle(1'b0, '0, 1'b1, r64());
      repeat (2) idle();

      // reset while a load is outstanding
      run_load(mk(7'h03, 3'b010, 5'd12, 1'b1, 2'd1, 64'd0, 0, 0, 0), 1, 64'h1);
      do_cycle(1'b1, mk(7'h03, 3'b010, 5'd13, 1'b1, 2'd1, 64'd0, 0, 0, 0), 1'b0, '0);
      repeat (2) do_cycle(1'b0, '0, 1'b0, '0);
      @(posedge clk);
      #1;
      rst_n       = 1'b0;
      d_valid     = 1'b0;
      d_rsp_valid = 1'b0;
      busy        = 1'b0;
      q[0].delete();
      q[1].delete();
      stray_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      do_cycle(1'b1, mk(7'h33, 3'd0, 5'd4, 1'b1, 2'd3, 64'h44, 0, 0, 0), 1'b0, '0);
      repeat (4) idle();

      check("drain_q", 0, 64'(q[0].size()), 64'd0);
      check("drain_q", 1, 64'(q[1].size()), 64'd0);
      check("drain_stray", 0, 64'(stray_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
